pico_io_bridge: RTL and testbench
=================================

PICO_IO_BRIDGE -- requirements
Module: pico_io_bridge

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning the stream FIFO depth in bytes (power of two, 2..16).
REQ-002 SHALL have parameter MEM_AW, default 8, meaning the data memory address width (2^MEM_AW bytes).
REQ-003 SHALL have port clk  input  1  system clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port port_id  input  8  processor I/O port number.
REQ-006 SHALL have port out_port  input  8  processor write data.
REQ-007 SHALL have port write_strobe  input  1  one-cycle processor write qualifier.
REQ-008 SHALL have port read_strobe  input  1  one-cycle processor read qualifier.
REQ-009 SHALL have port in_port  output  8  processor read data.
REQ-010 SHALL have port ld_en  input  1  memory preload write enable.
REQ-011 SHALL have port ld_addr  input  MEM_AW  memory preload address.
REQ-012 SHALL have port ld_data  input  8  memory preload data.
REQ-013 SHALL have port m_data  output  8  stream byte to downstream consumer.
REQ-014 SHALL have port m_valid  output  1  m_data valid.
REQ-015 SHALL have port m_ready  input  1  downstream accepts byte when high with m_valid.

Function
REQ-016 Port map SHALL be: 0x01 W address register; 0x02 R memory data; 0x03 W FIFO push; 0x04 R status; 0x05 W any value clears overflow flag.
REQ-017 Writes SHALL take effect only on a cycle with write_strobe=1 and a matching port_id; other port_ids ignored.
REQ-018 in_port SHALL be a combinational mux of port_id alone (independent of read_strobe): 0x02 -> mem_q, 0x04 -> status, all other ports -> 0x00.
REQ-019 Address register SHALL load out_port[MEM_AW-1:0] on a 0x01 write; it SHALL NOT auto-increment.
REQ-020 mem_q SHALL be a registered synchronous read of memory at the address register, updated every cycle; data SHALL be valid on in_port from the second cycle after the 0x01 write strobe.
REQ-021 ld_en SHALL write ld_data to ld_addr in one cycle; simultaneous ld_en to the currently addressed location SHALL make mem_q show old data that cycle and new data the next.
REQ-022 Status byte SHALL be: bit0 full, bit1 empty, bit2 overflow (sticky), bit3 0, bits[7:4] FIFO occupancy count (saturating display at 15).
REQ-023 Push on 0x03 write when not full SHALL enqueue out_port; push when full SHALL drop the byte and set overflow, even if a pop occurs the same cycle.
REQ-024 FIFO SHALL be first-word-fall-through: m_valid = not empty, m_data = head byte, pop on m_valid and m_ready.
REQ-025 Simultaneous accepted push and pop SHALL leave count unchanged; push into empty FIFO SHALL assert m_valid the following cycle.
REQ-026 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH with full at FIFO_DEPTH.
REQ-027 Overflow set and 0x05 clear in the same cycle SHALL leave overflow set.
REQ-028 read_strobe SHALL have no side effects (reads are non-destructive).

Reset
REQ-029 rst SHALL force: address register 0, mem_q 0x00, FIFO pointers and count 0, overflow 0, hence m_valid 0 and status 0x02.
REQ-030 Memory contents SHALL NOT be reset; FIFO contents lost on reset mid-operation.

Structure
REQ-031 Port number constants (0x01..0x05) and status bit positions SHALL live in shared package pico_io_pkg, used by both this block and processor-side code.
REQ-032 The FIFO SHALL be a separate sub-module sync_fifo (push/pop/full/empty/count), instanced once.

Verification
REQ-033 Preload mem[5]=0xA7, write 0x05 to port 0x01, set port_id=0x02 -> in_port=0xA7 two cycles after strobe.
REQ-034 Hold m_ready=0, push 0x11..0x18 on 0x03 -> status=0x81 (count 8, full); ninth push 0x99 -> status=0x85, FIFO contents unchanged.
REQ-035 Then m_ready=1 -> m_data 0x11..0x18 in order on consecutive cycles, then m_valid=0, status=0x06; write port 0x05 -> status=0x02.
REQ-036 Empty FIFO, m_ready=1, push 0x3C -> m_valid high next cycle with 0x3C, popped same cycle, status returns 0x02.
REQ-037 Count 3, push and pop same cycle for 10 cycles -> count stays 3, pointers wrap, order preserved.
REQ-038 Assert rst with count 5 and overflow set -> status=0x02, m_valid=0, in_port for port 0x07 reads 0x00.

Source files
------------

// File: rtl/pico_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pico_io_pkg
//  Description : Shared I/O port map and status-byte layout for the pico
//                processor I/O bridge and processor-side code.
//  Revision    : 1.0 - initial release
// ============================================================================
package pico_io_pkg;

  // Processor I/O port numbers
  typedef enum logic [7:0] {
    PORT_ADDR    = 8'h01,  // W: memory address register
    PORT_MEM     = 8'h02,  // R: memory read data
    PORT_PUSH    = 8'h03,  // W: stream FIFO push
    PORT_STATUS  = 8'h04,  // R: status byte
    PORT_OVF_CLR = 8'h05   // W: any value clears the overflow flag
  } port_e;

  // Status byte bit positions
  localparam int c_stat_full    = 0;
  localparam int c_stat_empty   = 1;
  localparam int c_stat_ovf     = 2;
  localparam int c_stat_cnt_lsb = 4;

  // Occupancy shown in a 4-bit status field, clamped at 15
  function automatic logic [3:0] sat_nibble(input logic [31:0] v);
    return (v > 32'd15) ? 4'hF : v[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pico_io_bridge_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : First-word-fall-through synchronous FIFO. Push is ignored
//                when full, pop is ignored when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_count == (c_aw+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_push_ok = push & ~full;
  assign w_pop_ok  = pop & ~empty;

  // Storage array, no reset: contents are meaningless once pointers clear
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Occupancy tracks accepted pushes minus accepted pops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/pico_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : pico_io_bridge
//  Description : Processor I/O bridge: address register + registered memory
//                read port, byte stream FIFO towards a downstream consumer,
//                and a status byte with sticky overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module pico_io_bridge
  import pico_io_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int MEM_AW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        port_id,
  input  logic [7:0]        out_port,
  input  logic              write_strobe,
  input  logic              read_strobe,
  output logic [7:0]        in_port,
  input  logic              ld_en,
  input  logic [MEM_AW-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready
);

  localparam int c_cw = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]        r_mem [2**MEM_AW];
  logic [MEM_AW-1:0] r_addr;
  logic [7:0]        r_mem_q;
  logic              r_ovf;

  logic              w_wr_addr;
  logic              w_wr_push;
  logic              w_wr_clr;
  logic              w_ovf_set;
  logic              w_full;
  logic              w_empty;
  logic [c_cw-1:0]   w_count;
  logic [31:0]       w_count_ext;
  logic [7:0]        w_status;
  logic              w_unused_rd;

  // Reads never change state, so the read qualifier is deliberately unused
  assign w_unused_rd = read_strobe;

  assign w_wr_addr   = write_strobe && (port_id == PORT_ADDR);
  assign w_wr_push   = write_strobe && (port_id == PORT_PUSH);
  assign w_wr_clr    = write_strobe && (port_id == PORT_OVF_CLR);
  // A push into a full FIFO is lost even if the consumer pops that cycle
  assign w_ovf_set   = w_wr_push && w_full;
  assign w_count_ext = 32'(w_count);

  assign m_valid     = ~w_empty;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_wr_push),
    .push_data (out_port),
    .pop       (m_ready),
    .pop_data  (m_data),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  // Data memory: preload-only write port, contents survive reset
  always_ff @(posedge clk) begin
    if (ld_en) r_mem[ld_addr] <= ld_data;
  end

  // Address register and registered memory read (old data on collision)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_mem_q <= 8'h00;
    end else begin
      if (w_wr_addr) r_addr <= out_port[MEM_AW-1:0];
      r_mem_q <= r_mem[r_addr];
    end
  end

  // Sticky overflow; a set in the same cycle as a clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (w_wr_clr) begin
      r_ovf <= 1'b0;
    end
  end

  // Status byte assembly
  always_comb begin
    w_status                            = 8'h00;
    w_status[c_stat_full]               = w_full;
    w_status[c_stat_empty]              = w_empty;
    w_status[c_stat_ovf]                = r_ovf;
    w_status[c_stat_cnt_lsb +: 4]       = sat_nibble(w_count_ext);
  end

  // Read mux selected by port number alone
  always_comb begin
    in_port = 8'h00;
    case (port_id)
      PORT_MEM:    in_port = r_mem_q;
      PORT_STATUS: in_port = w_status;
      default:     in_port = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pico_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pico_io_bridge
//  Description : Self-checking bench for pico_io_bridge: memory read table,
//                stream scoreboard, FIFO full/overflow/reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pico_io_bridge;

  localparam int DEPTH = 8;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    port_id;
  logic [7:0]    out_port;
  logic          write_strobe;
  logic          read_strobe;
  wire  [7:0]    in_port;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_data;
  wire  [7:0]    m_data;
  wire           m_valid;
  logic          m_ready;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] q[$];
  logic       m_ovf;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
    logic       rd;
  } mem_vec_t;

  mem_vec_t vec[5];

  pico_io_bridge #(
    .FIFO_DEPTH (DEPTH),
    .MEM_AW     (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .port_id      (port_id),
    .out_port     (out_port),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .in_port      (in_port),
    .ld_en        (ld_en),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready)
  );

  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_status();
    int n;
    n = q.size();
    return {((n > 15) ? 4'hF : 4'(n)), 1'b0, m_ovf, (n == 0), (n == DEPTH)};
  endfunction

  // One clock: scoreboard the stream at the falling edge, then advance past
  // the rising edge. Inputs are driven by the caller between ticks.
  task automatic tick();
    bit was_full;
    @(negedge clk);
    if (!rst) begin
      was_full = (q.size() == DEPTH);
      check8("m_valid", {7'b0, m_valid}, {7'b0, (q.size() != 0)});
      if (m_valid && m_ready && q.size() != 0) begin
        check8("stream_data", m_data, q[0]);
        void'(q.pop_front());
      end
      if (write_strobe && port_id == 8'h03) begin
        if (was_full) m_ovf = 1'b1;
        else          q.push_back(out_port);
      end else if (write_strobe && port_id == 8'h05) begin
        m_ovf = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string name, input logic [7:0] exp);
    port_id      = 8'h04;
    write_strobe = 1'b0;
    #1;
    check8(name, in_port, exp);
    check8({name, "_model"}, in_port, model_status());
  endtask

  task automatic push_byte(input logic [7:0] v);
    port_id      = 8'h03;
    out_port     = v;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
  endtask

  initial begin
    rst = 1'b1; port_id = 8'h00; out_port = 8'h00; write_strobe = 1'b0;
    read_strobe = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = 8'h00;
    m_ready = 1'b0; m_ovf = 1'b0;

    vec[0] = '{addr: 8'h05, data: 8'hA7, exp: 8'hA7, rd: 1'b0};
    vec[1] = '{addr: 8'h00, data: 8'h3C, exp: 8'h3C, rd: 1'b1};
    vec[2] = '{addr: 8'hFF, data: 8'h5A, exp: 8'h5A, rd: 1'b0};
    vec[3] = '{addr: 8'h80, data: 8'h01, exp: 8'h01, rd: 1'b1};
    vec[4] = '{addr: 8'h05, data: 8'hA7, exp: 8'hA7, rd: 1'b1};

    // Reset state
    #12;
    chk_status("rst_status", 8'h02);
    check8("rst_m_valid", {7'b0, m_valid}, 8'h00);
    port_id = 8'h02; #1;
    check8("rst_mem_q", in_port, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;

    // Memory preload then readback through address register
    foreach (vec[i]) begin
      ld_en = 1'b1; ld_addr = vec[i].addr; ld_data = vec[i].data;
      tick();
    end
    ld_en = 1'b0;
    foreach (vec[i]) begin
      port_id = 8'h01; out_port = vec[i].addr; write_strobe = 1'b1;
      tick();
      write_strobe = 1'b0; port_id = 8'h02; read_strobe = vec[i].rd;
      tick();
      check8($sformatf("mem_rd_%0d", i), in_port, vec[i].exp);
      tick();
      check8($sformatf("mem_hold_%0d", i), in_port, vec[i].exp);
      read_strobe = 1'b0;
    end

    // Unmatched port / missing strobe leave the address alone
    port_id = 8'h06; out_port = 8'h00; write_strobe = 1'b1; tick();
    port_id = 8'h01; out_port = 8'h00; write_strobe = 1'b0; tick();
    port_id = 8'h02; tick();
    check8("addr_ignored", in_port, 8'hA7);
    port_id = 8'h07; #1;
    check8("unmapped_port", in_port, 8'h00);
    port_id = 8'h01; #1;
    check8("write_only_port", in_port, 8'h00);

    // Preload collision at the current address: old then new
    port_id = 8'h02; ld_en = 1'b1; ld_addr = 8'h05; ld_data = 8'h4E;
    tick();
    ld_en = 1'b0;
    check8("collide_old", in_port, 8'hA7);
    tick();
    check8("collide_new", in_port, 8'h4E);

    // Fill to full, then overflow
    m_ready = 1'b0;
    for (int v = 8'h11; v <= 8'h18; v++) push_byte(8'(v));
    chk_status("full_status", 8'h81);
    check8("full_head", m_data, 8'h11);
    push_byte(8'h99);
    chk_status("ovf_status", 8'h85);
    check8("ovf_head", m_data, 8'h11);

    // Drain in order
    m_ready = 1'b1;
    port_id = 8'h04;
    for (int i = 0; i < 8; i++) tick();
    chk_status("drained_status", 8'h06);
    port_id = 8'h05; out_port = 8'h5A; write_strobe = 1'b1; tick();
    write_strobe = 1'b0;
    chk_status("ovf_clr_status", 8'h02);

    // Push into empty FIFO with consumer ready
    push_byte(8'h3C);
    port_id = 8'h04; #1;
    check8("fwft_valid", {7'b0, m_valid}, 8'h01);
    check8("fwft_data", m_data, 8'h3C);
    tick();
    chk_status("fwft_status", 8'h02);

    // Steady-state push and pop at count 3
    m_ready = 1'b0;
    push_byte(8'hA0); push_byte(8'hA1); push_byte(8'hA2);
    chk_status("cnt3_status", 8'h30);
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_byte(8'(8'hB0 + i));
    chk_status("cnt3_steady", 8'h30);
    for (int i = 0; i < 3; i++) tick();
    chk_status("cnt3_drained", 8'h02);

    // Reset with count 5 and overflow set
    m_ready = 1'b0;
    for (int i = 0; i < 9; i++) push_byte(8'(8'h40 + i));
    m_ready = 1'b1; port_id = 8'h04;
    for (int i = 0; i < 3; i++) tick();
    m_ready = 1'b0;
    chk_status("pre_rst_status", 8'h54);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    m_ovf = 1'b0;
    chk_status("mid_rst_status", 8'h02);
    check8("mid_rst_m_valid", {7'b0, m_valid}, 8'h00);
    port_id = 8'h07; #1;
    check8("mid_rst_port7", in_port, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_status("post_rst_status", 8'h02);
    m_ready = 1'b1;
    push_byte(8'h77);
    tick();
    chk_status("post_rst_final", 8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
